// File: rtl/glyph_pkg.sv
// Shared constants and types for the glyph RAM write path.
// The build macro GLYPH_WRITER_TRANSPARENT_EN only affects glyph_writer, not this package.
package glyph_pkg;

  localparam int PIX_W       = 24;
  localparam int ADDR_W      = 17;
  localparam int GLYPH_SHIFT = 8;
  localparam int IDX_W       = 8;
  localparam int CNT_W       = IDX_W + GLYPH_SHIFT;

  localparam int GLYPH_PIXELS = 1 << GLYPH_SHIFT;

  localparam logic [PIX_W-1:0] TRANSPARENT = 24'hFF00FF;

  typedef enum logic [1:0] {
    OP_WRITE    = 2'b00,
    OP_FILL     = 2'b01,
    OP_FILL_ALL = 2'b10,
    OP_ILLEGAL  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FILL   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // First RAM word of a glyph: index scaled by the glyph size.
  function automatic logic [ADDR_W-1:0] glyph_base(input logic [IDX_W-1:0] idx);
    logic [ADDR_W-1:0] r;
    r = ADDR_W'(idx) << GLYPH_SHIFT;
    return r;
  endfunction

endpackage

// File: rtl/glyph_addr_gen.sv
// Base register plus pixel counter; yields the RAM address and a last-pixel flag.
// Also used by the read-side address logic.
module glyph_addr_gen
  import glyph_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [CNT_W-1:0]  last_cnt_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  last_cnt_q, last_cnt_d;

  always_comb begin
    base_d     = base_q;
    cnt_d      = cnt_q;
    last_cnt_d = last_cnt_q;
    if (load_i) begin
      base_d     = base_i;
      cnt_d      = '0;
      last_cnt_d = last_cnt_i;
    end else if (step_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q     <= '0;
      cnt_q      <= '0;
      last_cnt_q <= '0;
    end else begin
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      last_cnt_q <= last_cnt_d;
    end
  end

  // The counter is at most CNT_W bits, so base+cnt stays inside the glyph area.
  assign addr_o = base_q + ADDR_W'(cnt_q);
  assign last_o = (cnt_q == last_cnt_q);

endmodule

// File: rtl/glyph_writer.sv
// Loads glyphs into the glyph RAM write port: pixel streaming, per-glyph fill and whole-memory fill.
// Define GLYPH_WRITER_TRANSPARENT_EN to skip RAM writes for streamed pixels equal to TRANSPARENT.
module glyph_writer
  import glyph_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [IDX_W-1:0]  cmd_glyph,
  input  logic [PIX_W-1:0]  cmd_color,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              abort,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output state_t            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // ready depends only on state, never on valid.
  state_t            state_q;
  logic [PIX_W-1:0]  color_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [PIX_W-1:0]  wr_data_q;
  logic              done_q;
  logic              err_q;

  op_t               op;
  logic              cmd_hs;
  logic              pix_hs;
  logic              pix_write;
  logic              gen_load;
  logic              gen_step;
  logic [ADDR_W-1:0] gen_base;
  logic [CNT_W-1:0]  gen_last_cnt;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_last;

  assign op        = op_t'(cmd_op);
  assign cmd_ready = (state_q == ST_IDLE);
  assign pix_ready = (state_q == ST_STREAM);
  assign busy      = (state_q != ST_IDLE);
  assign cmd_hs    = cmd_valid & cmd_ready;
  assign pix_hs    = pix_valid & pix_ready;

`ifdef GLYPH_WRITER_TRANSPARENT_EN
  assign pix_write = (pix_data != TRANSPARENT);
`else
  assign pix_write = 1'b1;
`endif

  assign gen_load     = cmd_hs & (op != OP_ILLEGAL);
  assign gen_step     = pix_hs | (state_q == ST_FILL);
  assign gen_base     = (op == OP_FILL_ALL) ? '0 : glyph_base(cmd_glyph);
  assign gen_last_cnt = (op == OP_FILL_ALL) ? '1 : CNT_W'(GLYPH_PIXELS - 1);

  glyph_addr_gen u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load_i     (gen_load),
    .base_i     (gen_base),
    .last_cnt_i (gen_last_cnt),
    .step_i     (gen_step),
    .addr_o     (gen_addr),
    .last_o     (gen_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      color_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_hs) begin
            color_q <= cmd_color;
            case (op)
              OP_WRITE:             state_q <= ST_STREAM;
              OP_FILL, OP_FILL_ALL: state_q <= ST_FILL;
              default:              err_q   <= 1'b1;
            endcase
          end
        end
        ST_STREAM: begin
          if (pix_hs) begin
            wr_en_q   <= pix_write;
            wr_addr_q <= gen_addr;
            wr_data_q <= pix_data;
          end
          // The write captured in an abort cycle still goes out; only completion is cancelled.
          if (abort)                 state_q <= ST_IDLE;
          else if (pix_hs && gen_last) state_q <= ST_DONE;
        end
        ST_FILL: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= gen_addr;
          wr_data_q <= color_q;
          if (abort)         state_q <= ST_IDLE;
          else if (gen_last) state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_glyph_writer.sv
// Self-checking bench for glyph_writer: a reference model queues every expected RAM write,
// and a negedge monitor pops and compares each write the DUT issues.
module tb_glyph_writer;
  import glyph_pkg::*;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [IDX_W-1:0]  cmd_glyph;
  logic [PIX_W-1:0]  cmd_color;
  logic              pix_valid;
  logic              pix_ready;
  logic [PIX_W-1:0]  pix_data;
  logic              abort;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              busy;
  logic              done;
  logic              err;
  state_t            dbg_state;

  localparam int WW = ADDR_W + PIX_W;

  logic [WW-1:0]    exp_q[$];
  logic [WW-1:0]    exp_word;
  logic [PIX_W-1:0] px_buf[256];
  int               vectors;
  int               miscompares;
  int               done_cnt;
  int               done_base;

  glyph_writer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_glyph (cmd_glyph),
    .cmd_color (cmd_color),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .abort     (abort),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit written(input logic [PIX_W-1:0] p);
`ifdef GLYPH_WRITER_TRANSPARENT_EN
    return p != TRANSPARENT;
`else
    return 1'b1;
`endif
  endfunction

  // Reference model: glyph g occupies words g*256 .. g*256+255, pixel i at offset i.
  task automatic model_stream(input int glyph, input int n);
    for (int i = 0; i < n; i++)
      if (written(px_buf[i]))
        exp_q.push_back({ADDR_W'(glyph * 256 + i), px_buf[i]});
  endtask

  task automatic model_fill(input int first_addr, input int n, input logic [PIX_W-1:0] color);
    for (int i = 0; i < n; i++)
      exp_q.push_back({ADDR_W'(first_addr + i), color});
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", wr_addr, wr_data);
      end else begin
        exp_word = exp_q.pop_front();
        check("ram_write", {wr_addr, wr_data}, exp_word);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  task automatic issue_cmd(input logic [1:0] op, input int glyph, input logic [PIX_W-1:0] color);
    wait_idle(2000);
    done_base = done_cnt;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_glyph = IDX_W'(glyph);
    cmd_color = color;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic finish_op(input int expect_done);
    wait_idle(2000);
    @(posedge clk); #1;
    check("done_count", done_cnt - done_base, expect_done);
  endtask

  // gap_mode: 0 continuous, 1 one idle cycle between pixels, 2 random idle cycles.
  task automatic stream(input int n_send, input int gap_mode, input bit abort_last);
    int g;
    for (int i = 0; i < n_send; i++) begin
      g = (gap_mode == 1) ? ((i > 0) ? 1 : 0) : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
      repeat (g) begin
        pix_valid = 1'b0;
        pix_data  = $urandom();
        @(posedge clk); #1;
        if (gap_mode == 1) check("gap_wr_en", wr_en, 0);
      end
      pix_valid = 1'b1;
      pix_data  = px_buf[i];
      abort     = abort_last && (i == n_send - 1);
      @(posedge clk); #1;
      pix_valid = 1'b0;
      abort     = 1'b0;
      if (gap_mode == 1) check("pix_wr_en", wr_en, written(px_buf[i]));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int glyph;
    logic [PIX_W-1:0] color;
    vectors = 0; miscompares = 0; done_cnt = 0; done_base = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_glyph = '0; cmd_color = '0;
    pix_valid = 1'b0; pix_data = '0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_pix_ready", pix_ready, 0);

    // WRITE_GLYPH 3, pixel i = i, continuous valid, with done timing
    for (int i = 0; i < 256; i++) px_buf[i] = PIX_W'(i);
    model_stream(3, 256);
    issue_cmd(2'b00, 3, '0);
    check("stream_pix_ready", pix_ready, 1);
    check("stream_cmd_ready", cmd_ready, 0);
    stream(256, 0, 1'b0);
    check("last_write_en", wr_en, written(px_buf[255]));
    check("done_not_yet", done, 0);
    @(posedge clk); #1;
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    check("done_width", done, 0);
    finish_op(1);

    // Same stream with valid toggled every other cycle
    model_stream(3, 256);
    issue_cmd(2'b00, 3, '0);
    stream(256, 1, 1'b0);
    finish_op(1);

    // FILL_GLYPH 255: accept edge through the first IDLE cycle counts 258 edges
    model_fill(16'hFF00, 256, 24'h123456);
    issue_cmd(2'b01, 255, 24'h123456);
    n = 1;
    while (busy && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("fill_cycles", n, 258);
    finish_op(1);

    // Illegal opcode
    issue_cmd(2'b11, 9, 24'hABCDEF);
    check("illegal_err", err, 1);
    check("illegal_busy", busy, 0);
    check("illegal_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    check("illegal_err_width", err, 0);
    finish_op(0);

    // Abort after 10 pixels
    for (int i = 0; i < 256; i++) px_buf[i] = $urandom();
    model_stream(40, 10);
    issue_cmd(2'b00, 40, '0);
    stream(10, 2, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_stream_idle", busy, 0);
    finish_op(0);

    // Abort during FILL: abort raised after 20 edges, so 21 writes land
    model_fill(17 * 256, 21, 24'h00C0DE);
    issue_cmd(2'b01, 17, 24'h00C0DE);
    repeat (20) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_fill_idle", busy, 0);
    finish_op(0);

    // Abort together with the 256th pixel: pixel written, no done
    for (int i = 0; i < 256; i++) px_buf[i] = $urandom();
    model_stream(200, 256);
    issue_cmd(2'b00, 200, '0);
    stream(256, 0, 1'b1);
    check("abort_last_idle", busy, 0);
    finish_op(0);

    // Commands and pixels offered while filling are ignored; abort in IDLE ignored
    color = $urandom();
    model_fill(20 * 256, 256, color);
    abort = 1'b1;
    issue_cmd(2'b01, 20, color);
    abort = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_glyph = 8'd9;
    pix_valid = 1'b1; pix_data = $urandom();
    repeat (3) begin
      check("busy_cmd_ready", cmd_ready, 0);
      check("busy_pix_ready", pix_ready, 0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0; pix_valid = 1'b0;
    finish_op(1);

    // Randomized glyph writes and fills
    for (int it = 0; it < 6; it++) begin
      glyph = $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < 256; i++) px_buf[i] = $urandom();
        if (it < 2) begin
          px_buf[5] = TRANSPARENT;
          px_buf[6] = TRANSPARENT;
        end
        model_stream(glyph, 256);
        issue_cmd(2'b00, glyph, '0);
        stream(256, 2, 1'b0);
      end else begin
        color = $urandom();
        model_fill(glyph * 256, 256, color);
        issue_cmd(2'b01, glyph, color);
      end
      finish_op(1);
    end

    // Reset in the middle of FILL_ALL with the counter at 100
    color = $urandom();
    model_fill(0, 100, color);
    issue_cmd(2'b10, 77, color);
    repeat (100) @(posedge clk);
    #6 rst = 1'b1;
    #1;
    check("midrst_wr_en", wr_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_writes_seen", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
    check("midrst_no_done", done_cnt - done_base, 0);

    // Next command after reset runs normally
    color = $urandom();
    model_fill(7 * 256, 256, color);
    issue_cmd(2'b01, 7, color);
    finish_op(1);

    repeat (3) @(posedge clk);
    #1 check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/glyph_writer.md
Name: glyph_writer

Overview:
- Write-side counterpart of the glyph ROM: loads 16x16 glyphs of 24-bit pixels into the dual-port glyph RAM that the VGA pixel path reads.
- Accepts commands from the CPU/loader over a valid/ready handshake and issues registered writes (wr_en/wr_addr/wr_data) to the RAM's write port.
- Supports per-glyph pixel streaming, per-glyph solid fill, and whole-memory fill (screen-font clear).

Parameters:
- PIX_W, 24, pixel width (RGB888)
- ADDR_W, 17, glyph memory address width
- GLYPH_SHIFT, 8, log2(pixels per glyph); 16x16 gives 256
- IDX_W, 8, glyph index width; 256 glyphs
- TRANSPARENT, 24'hFF00FF, key colour; used only with the optional feature

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  00 WRITE_GLYPH, 01 FILL_GLYPH, 10 FILL_ALL, 11 illegal
- cmd_glyph  in  IDX_W  target glyph index
- cmd_color  in  PIX_W  fill colour for fill ops
- pix_valid  in  1  stream pixel offered
- pix_ready  out  1  high only in STREAM
- pix_data  in  PIX_W  stream pixel, row-major, col fastest
- abort  in  1  synchronous cancel of the current operation
- wr_en  out  1  RAM write strobe, registered
- wr_addr  out  ADDR_W  RAM write address, registered
- wr_data  out  PIX_W  RAM write data, registered
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on normal completion
- err  out  1  one-cycle pulse on illegal opcode

Behaviour:
- Reset (async): state=IDLE, cnt=0, base=0. wr_en, wr_addr, wr_data, done, err, busy are all 0. cmd_ready=1 and pix_ready=0 follow IDLE.
- Reset mid-operation: wr_en drops immediately. Partial glyph data is left in RAM. No done pulse.
- States: IDLE, STREAM, FILL, DONE.
- IDLE, on cmd_valid&cmd_ready:
  - Latch op, colour, base = cmd_glyph<<GLYPH_SHIFT; cnt=0.
  - WRITE_GLYPH -> STREAM.
  - FILL_GLYPH -> FILL with limit 2^GLYPH_SHIFT.
  - FILL_ALL -> FILL with base=0, limit 2^ADDR_W-... capped at IDX_W+GLYPH_SHIFT bits (65536 writes).
  - op 11 -> err=1 for one cycle, remain IDLE, no writes.
- STREAM:
  - Each pix_valid&pix_ready: next cycle wr_en=1, wr_addr=base+cnt, wr_data=pix_data; cnt++.
  - Cycles with no handshake: wr_en=0.
  - After the 256th accepted pixel -> DONE.
- FILL:
  - One write per cycle: wr_addr=base+cnt, wr_data=colour; cnt++.
  - After the last write -> DONE. No back-pressure.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: handshake-to-wr_en is 1 cycle. cmd accept to first fill write is 1 cycle.
- abort (STREAM/FILL): next state is IDLE. No done. The write registered in the abort cycle still completes. abort in IDLE/DONE is ignored.
- Simultaneous abort and the last pixel: abort wins. No done.
- Address arithmetic is unsigned. cnt width is IDX_W+GLYPH_SHIFT. Writes never wrap past 2^(IDX_W+GLYPH_SHIFT)-1.
- cmd_valid while busy: ignored (cmd_ready=0). pix_valid outside STREAM: ignored.

Optional Feature:
- Macro GLYPH_WRITER_TRANSPARENT_EN.
- Defined: in STREAM, a pixel equal to TRANSPARENT is accepted and cnt advances, but wr_en stays 0 for that pixel. The RAM keeps its old value, allowing glyph overlay. Fill ops are unaffected.
- Undefined: every accepted pixel is written.

Decomposition:
- Package glyph_pkg holds:
  - PIX_W, GLYPH_SHIFT, IDX_W, ADDR_W constants.
  - op_t enum (OP_WRITE, OP_FILL, OP_FILL_ALL, OP_ILLEGAL).
  - state_t enum.
- Sub-module glyph_addr_gen: base register plus counter, producing address and a last flag. Shared with the read-side address logic.

Test Plan:
- Reset mid-FILL_ALL at cnt=100 -> wr_en=0 asynchronously, busy=0, no done; the next command is accepted normally.
- WRITE_GLYPH glyph=3, 256 pixels 0x000000..0x0000FF with continuous valid -> writes at 0x300..0x3FF with data equal to the low byte of the index; done 1 cycle after the last write; cmd_ready returns.
- Same stream with pix_valid toggled every other cycle -> identical RAM contents, with wr_en gaps matching the gaps in pix_valid.
- FILL_GLYPH glyph=255, colour 0x123456 -> 256 consecutive writes 0xFF00..0xFFFF, exactly 258 cycles from accept to IDLE.
- cmd_op=11 -> err pulse of 1 cycle, no wr_en, busy stays 0. abort after 10 pixels of WRITE_GLYPH -> exactly 10 writes, no done.
- With GLYPH_WRITER_TRANSPARENT_EN: pixels 5 and 6 = 0xFF00FF -> addresses base+5 and base+6 are not written, and the other 254 are.
